// File: rtl/timer_counter.sv
// Prescaled up/down timer with one-shot or auto-reload operation.
// It pulses tc_pulse and raises a sticky irq when the count reaches its terminal value.
module timer_counter #(
  parameter int WIDTH      = 24,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  irq_clr,
  output logic [WIDTH-1:0]      count,
  output logic                  tc_pulse,
  output logic                  irq,
  output logic                  running
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]      ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] ZERO_P = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] ONE_P  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                  state_r, state_nxt_s;
  logic [WIDTH-1:0]        count_r, count_nxt_s;
  logic [WIDTH-1:0]        reload_r, reload_nxt_s;
  logic [PRESCALE_W-1:0]   pre_cnt_r, pre_cnt_nxt_s;
  logic                    tick_s, terminal_s;
  logic                    tc_pulse_r, irq_r, running_r;

  // Next-state, prescaler and counter update; load overrides any same-cycle tick
  always_comb begin
    state_nxt_s   = state_r;
    count_nxt_s   = count_r;
    reload_nxt_s  = reload_r;
    pre_cnt_nxt_s = pre_cnt_r;
    tick_s        = 1'b0;
    terminal_s    = 1'b0;

    if (load) begin
      reload_nxt_s  = load_value;
      pre_cnt_nxt_s = ZERO_P;
      state_nxt_s   = ST_RUN;
      count_nxt_s   = dir ? ZERO_W : load_value;
    end else if ((state_r == ST_RUN) && en) begin
      // >= so that a prescale lowered mid-run takes effect immediately
      if (pre_cnt_r >= prescale) begin
        tick_s        = 1'b1;
        pre_cnt_nxt_s = ZERO_P;
      end else begin
        pre_cnt_nxt_s = pre_cnt_r + ONE_P;
      end
    end else begin
      pre_cnt_nxt_s = pre_cnt_r;
    end

    if (tick_s) begin
      if (dir == 1'b0) begin
        if (count_r != ZERO_W) begin
          count_nxt_s = count_r - ONE_W;
        end else begin
          terminal_s = 1'b1;
        end
      end else begin
        if (count_r != reload_r) begin
          count_nxt_s = count_r + ONE_W;
        end else begin
          terminal_s = 1'b1;
        end
      end
    end else begin
      terminal_s = 1'b0;
    end

    if (terminal_s) begin
      if (auto_reload) begin
        count_nxt_s = dir ? ZERO_W : reload_r;
      end else begin
        state_nxt_s = ST_DONE;
      end
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State and output registers; irq set wins over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      count_r    <= ZERO_W;
      reload_r   <= ZERO_W;
      pre_cnt_r  <= ZERO_P;
      tc_pulse_r <= 1'b0;
      irq_r      <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      reload_r   <= reload_nxt_s;
      pre_cnt_r  <= pre_cnt_nxt_s;
      tc_pulse_r <= terminal_s;
      irq_r      <= terminal_s | (irq_r & ~irq_clr);
      running_r  <= (state_nxt_s == ST_RUN);
    end
  end

  assign count    = count_r;
  assign tc_pulse = tc_pulse_r;
  assign irq      = irq_r;
  assign running  = running_r;

endmodule
